// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter: FSM state
// encodings, internal accumulator depth and the overflow-digit helper.
package bin2bcd_seq_pkg;

    localparam int BCD_INT_DIGITS = 10;
    localparam int BCD_ACC_W      = 4 * BCD_INT_DIGITS;

    typedef enum logic [1:0] {
        BCD_S_IDLE  = 2'd0,
        BCD_S_SHIFT = 2'd1,
        BCD_S_DONE  = 2'd2
    } bcd_state_t;

    // True when any accumulator digit at or above index 'digits' is non-zero,
    // i.e. the value does not fit in the displayed digit count.
    function automatic logic hi_digits_nz(input logic [BCD_ACC_W-1:0] acc,
                                          input int digits);
        logic nz;
        nz = 1'b0;
        for (int i = 0; i < BCD_INT_DIGITS; i++) begin
            if (i >= digits && acc[4*i +: 4] != 4'd0) nz = 1'b1;
        end
        return nz;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more so the
// following left shift carries correctly into the next digit.
module bcd_digit_adj (
    input  logic [3:0] d,
    output logic [3:0] q
);

    assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one bit per clock (shift-and-add-3).
// Optional macro BIN2BCD_OVF_SAT_EN: saturate bcd_out to all nines on overflow.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int BIN_W  = 32,
    parameter int DIGITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                in_valid,
    input  logic [BIN_W-1:0]    bin_in,
    output logic                in_ready,
    output logic                out_valid,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                ovf
);

    localparam int CW = $clog2(BIN_W + 1);

    bcd_state_t           state, state_nxt;
    logic [CW-1:0]        cnt;
    logic [BIN_W-1:0]     sr;
    logic [BCD_ACC_W-1:0] acc;
    logic [BCD_ACC_W-1:0] adj;
    logic [BCD_ACC_W-1:0] acc_shf;
    logic [4*DIGITS-1:0]  bcd_nxt;
    logic                 accept;
    logic                 last;
    logic                 hi_nz;
    logic                 adj_unused;

    for (genvar g = 0; g < BCD_INT_DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d (acc[4*g +: 4]),
            .q (adj[4*g +: 4])
        );
    end

    // Top digit never carries out for legal BIN_W, so its MSB is dropped.
    assign adj_unused = adj[BCD_ACC_W-1];
    assign acc_shf    = {adj[BCD_ACC_W-2:0], sr[BIN_W-1]};

    assign last     = (cnt == CW'(BIN_W - 1));
    assign in_ready = en && (state == BCD_S_IDLE);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            BCD_S_IDLE:  if (accept) state_nxt = BCD_S_SHIFT;
            BCD_S_SHIFT: if (last)   state_nxt = BCD_S_DONE;
            BCD_S_DONE:  state_nxt = BCD_S_IDLE;
            default:     state_nxt = BCD_S_IDLE;
        endcase
    end

    always_comb begin
        hi_nz = hi_digits_nz(acc_shf, DIGITS);
`ifdef BIN2BCD_OVF_SAT_EN
        bcd_nxt = hi_nz ? {DIGITS{4'h9}} : acc_shf[4*DIGITS-1:0];
`else
        bcd_nxt = acc_shf[4*DIGITS-1:0];
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= BCD_S_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            sr        <= '0;
            acc       <= '0;
            bcd_out   <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (accept) begin
                sr  <= bin_in;
                acc <= '0;
                cnt <= '0;
            end else if (state == BCD_S_SHIFT) begin
                acc <= acc_shf;
                sr  <= sr << 1;
                cnt <= cnt + CW'(1);
                // Results are captured from the post-shift value on the final bit.
                if (last) begin
                    bcd_out   <= bcd_nxt;
                    ovf       <= hi_nz;
                    out_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomized self-checking bench for bin2bcd_seq against an arithmetic model.
module tb_bin2bcd_seq;

    localparam int BIN_W  = 32;
    localparam int DIGITS = 8;

    logic                clk = 1'b0;
    logic                reset;
    logic                en;
    logic                in_valid;
    logic [BIN_W-1:0]    bin_in;
    logic                in_ready;
    logic                out_valid;
    logic [4*DIGITS-1:0] bcd_out;
    logic                ovf;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int pulses = 0;
    int acc_q[$];

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .in_valid  (in_valid),
        .bin_in    (bin_in),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .bcd_out   (bcd_out),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Acceptance log: values read here are the pre-edge ones.
    always @(posedge clk) begin
        cyc++;
        if (!reset && in_valid && in_ready) acc_q.push_back(cyc);
    end

    always @(negedge clk) if (out_valid) pulses++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Decimal digits by plain division, then optional saturation.
    task automatic model(input longint unsigned v, output logic [31:0] bcd, output logic o);
        longint unsigned lim = 1;
        longint unsigned r;
        for (int i = 0; i < DIGITS; i++) lim = lim * 10;
        o = (v >= lim);
        r = v % lim;
        bcd = '0;
        for (int i = 0; i < DIGITS; i++) begin
            bcd[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
`ifdef BIN2BCD_OVF_SAT_EN
        if (o) bcd = 32'h99999999;
`endif
    endtask

    task automatic wait_out(input string tag, output int t);
        t = 0;
        while (!out_valid && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_seen"}, 64'(out_valid), 64'd1);
    endtask

    task automatic run_one(input logic [31:0] v);
        logic [31:0] eb;
        logic        eo;
        int          t;
        int          p0;
        model(longint'(v), eb, eo);
        @(negedge clk);
        chk("ready_idle", 64'(in_ready), 64'd1);
        bin_in   = v;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        bin_in   = $urandom;
        p0 = pulses;
        wait_out("conv", t);
        chk("latency", 64'(t), 64'd32);
        chk("bcd", 64'(bcd_out), 64'(eb));
        chk("ovf", 64'(ovf), 64'(eo));
        @(negedge clk);
        chk("pulse_once", 64'(out_valid), 64'd0);
        chk("pulse_cnt", 64'(pulses - p0), 64'd1);
        chk("bcd_hold", 64'(bcd_out), 64'(eb));
    endtask

    initial begin
        int t, n0, p0, a0;
        logic [31:0] eb;
        logic        eo;

        reset = 1'b1; en = 1'b1; in_valid = 1'b0; bin_in = '0;
        #1;
        chk("rst_bcd", 64'(bcd_out), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_ready", 64'(in_ready), 64'd1);
        chk("idle_pulses", 64'(pulses), 64'd0);
        chk("idle_bcd", 64'(bcd_out), 64'd0);

        run_one(32'd12345678);
        run_one(32'd0);
        run_one(32'd99999999);
        run_one(32'd100000000);
        run_one(32'hFFFFFFFF);
        for (int i = 0; i < 12; i++) begin
            case (i % 3)
                0: run_one($urandom);
                1: run_one($urandom_range(99999999, 0));
                default: run_one($urandom_range(999, 0));
            endcase
        end

        // Back-to-back with in_valid held: bin_in change during SHIFT is ignored.
        @(negedge clk);
        n0 = acc_q.size();
        bin_in = 32'd5; in_valid = 1'b1;
        @(negedge clk);
        bin_in = 32'd7;
        wait_out("b2b0", t);
        chk("b2b0_bcd", 64'(bcd_out), 64'h5);
        t = 0;
        while (acc_q.size() < n0 + 2 && t < 50) begin
            @(negedge clk);
            t++;
        end
        in_valid = 1'b0;
        chk("b2b_accepts", 64'(acc_q.size() - n0), 64'd2);
        if (acc_q.size() >= n0 + 2)
            chk("b2b_spacing", 64'(acc_q[n0+1] - acc_q[n0]), 64'd34);
        wait_out("b2b1", t);
        chk("b2b1_bcd", 64'(bcd_out), 64'h7);

        // Reset at shift 10 aborts with no pulse.
        @(negedge clk);
        bin_in = 32'd87654321; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        p0 = pulses;
        reset = 1'b1;
        #1;
        chk("mid_rst_bcd", 64'(bcd_out), 64'd0);
        chk("mid_rst_ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("mid_rst_nopulse", 64'(pulses - p0), 64'd0);
        chk("mid_rst_hold", 64'(bcd_out), 64'd0);

        // Dropping en mid-conversion does not abort and blocks new acceptances.
        @(negedge clk);
        bin_in = 32'd4242; in_valid = 1'b1;
        @(negedge clk);
        bin_in = 32'd1111;
        repeat (5) @(negedge clk);
        en = 1'b0;
        wait_out("en_low", t);
        model(64'd4242, eb, eo);
        chk("en_low_bcd", 64'(bcd_out), 64'(eb));
        a0 = acc_q.size();
        repeat (40) @(negedge clk);
        chk("en_low_ready", 64'(in_ready), 64'd0);
        chk("en_low_noacc", 64'(acc_q.size() - a0), 64'd0);
        in_valid = 1'b0;
        en = 1'b1;
        run_one($urandom);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
